mc_ctrl: RTL
============

# mc_ctrl

Multi-cycle control unit for the MIPS datapath. It is the producer side of the ALU operation interface. It sequences each instruction through fetch, decode, execute, memory and writeback states. From the latched opcode/funct it drives the 4-bit ALU op code, the datapath mux selects and the write enables, and it consumes the ALU zero flag for branch resolution. It also stalls on a memory ready handshake.

## Interface
Parameters:
- none; all encodings are fixed constants in the shared package.

Ports:
- clk  in  1  system clock; all state updates on rising edge.
- rst  in  1  reset, asynchronous, active-high; forces state FETCH.
- opcode  in  6  IR[31:26]; stable from DECODE until the next FETCH completes.
- funct  in  6  IR[5:0]; same stability as opcode.
- zero  in  1  ALU z flag; sampled only in BRANCH.
- mem_rdy  in  1  memory completes the current access this cycle.
- mem_req  out  1  memory access request.
- mem_we  out  1  memory write (sw).
- iord  out  1  memory address select: 0 = PC, 1 = ALUOut.
- ir_we  out  1  IR load.
- pc_we  out  1  PC load.
- pc_src  out  2  0 = ALU result (PC+4), 1 = ALUOut (branch target), 2 = jump {PC[31:28], IR[25:0], 2'b00}.
- rf_we  out  1  register file write.
- reg_dst  out  1  0 = rt, 1 = rd.
- mem_to_reg  out  1  0 = ALUOut, 1 = MDR.
- alu_src_a  out  2  0 = PC, 1 = rs, 2 = shamt zero-extended.
- alu_src_b  out  3  0 = rt, 1 = constant 4, 2 = sign-ext imm, 3 = zero-ext imm, 4 = sign-ext imm << 2.
- alu_op  out  4  0 NOP, 1 ADD, 2 SUB, 3 AND, 4 OR, 5 XOR, 6 SLL (b<<a), 7 SRL, 8 SRA, 9 LUI.
- illegal  out  1  unsupported instruction, one-cycle pulse.

## Operation
- States: FETCH, DECODE, MEM_ADDR, MEM_READ, MEM_WB, MEM_WRITE, EXEC_R, EXEC_I, ALU_WB, BRANCH, JUMP.
- Outputs not listed for a state are 0.
- FETCH:
  - Outputs: mem_req=1, iord=0, alu_src_a=0, alu_src_b=1, alu_op=ADD, pc_src=0.
  - ir_we = pc_we = mem_rdy. Advance to DECODE only when mem_rdy=1; otherwise hold.
- DECODE:
  - Outputs: alu_src_a=0, alu_src_b=4, alu_op=ADD (branch target into ALUOut).
  - Next state by opcode: 0x00 → EXEC_R; 0x23/0x2B → MEM_ADDR; 0x04/0x05 → BRANCH; 0x02 → JUMP; 0x08/0x09/0x0C/0x0D/0x0E/0x0F → EXEC_I.
  - Any other opcode, or opcode 0x00 with unsupported funct: illegal=1, next FETCH.
- EXEC_R (funct → op):
  - Register ops, alu_src_a=1, alu_src_b=0: 0x20/0x21 ADD, 0x22/0x23 SUB, 0x24 AND, 0x25 OR, 0x26 XOR.
  - Shift ops, alu_src_a=2, alu_src_b=0: 0x00 SLL, 0x02 SRL, 0x03 SRA.
  - Next ALU_WB.
- EXEC_I: alu_src_a=1. Next ALU_WB.
  - addi/addiu: ADD, alu_src_b=2.
  - andi/ori/xori: AND/OR/XOR, alu_src_b=3.
  - lui: LUI, alu_src_b=3.
- ALU_WB: rf_we=1, mem_to_reg=0, reg_dst=1 for R-type and 0 for I-type. Next FETCH.
- MEM_ADDR: alu_src_a=1, alu_src_b=2, alu_op=ADD. Next MEM_READ (lw) or MEM_WRITE (sw).
- MEM_READ: mem_req=1, iord=1. Next MEM_WB on mem_rdy; otherwise hold.
- MEM_WRITE: mem_req=1, mem_we=1, iord=1. Next FETCH on mem_rdy; otherwise hold.
- MEM_WB: rf_we=1, mem_to_reg=1, reg_dst=0. Next FETCH.
- BRANCH:
  - Outputs: alu_src_a=1, alu_src_b=0, alu_op=SUB, pc_src=1.
  - pc_we = zero for beq, ~zero for bne. Next FETCH.
- JUMP: pc_src=2, pc_we=1. Next FETCH.

## Timing
- State register updates on the rising edge of clk. Outputs are combinational from state, latched opcode/funct, and (for pc_we/ir_we) mem_rdy and zero.
- Reset behaviour:
  - rst asserted mid-instruction (any state, including a stalled MEM_READ/MEM_WRITE) forces FETCH immediately and asynchronously.
  - While rst=1, all write enables are forced to 0 regardless of mem_rdy.
  - After deassertion, outputs are the FETCH values: mem_req=1, alu_op=1, alu_src_b=1, all other selects 0, illegal=0.
- Latency with zero wait states:
  - R-type and I-type ALU: 4 cycles.
  - lw: 5 cycles.
  - sw: 4 cycles.
  - beq/bne: 3 cycles.
  - j: 3 cycles.
  - illegal: 2 cycles.
- Each cycle with mem_rdy=0 in FETCH, MEM_READ or MEM_WRITE adds one cycle. During such a stall:
  - all outputs stay constant;
  - rf_we, pc_we and ir_we stay 0.
- mem_rdy is ignored outside those three states.
- pc_we and rf_we never assert in the same cycle. At most one write enable is high per cycle, except ir_we+pc_we in FETCH.

## Structure
- Package mc_pkg holds:
  - ALU op constants (values above, shared with the ALU);
  - state enum;
  - alu_src_a/alu_src_b/pc_src encodings;
  - opcode and funct constants.
- Sub-module mc_ctrl_dec (combinational) maps opcode/funct to {instruction class, alu_op, alu_src_b, legal}.
- mc_ctrl holds the state register and the per-state output logic.

## Test plan
- Reset during a stalled MEM_READ (mem_rdy=0) → FETCH in the same cycle, rf_we=0, mem_we=0; after release mem_req=1, alu_op=1.
- add (op 0x00, funct 0x20), mem_rdy=1 → EXEC_R alu_op=1, src_a=1, src_b=0; ALU_WB rf_we=1, reg_dst=1; back to FETCH after 4 cycles.
- lw (0x23) with mem_rdy low 3 cycles in MEM_READ → holds with mem_req=1, iord=1; then MEM_WB rf_we=1, mem_to_reg=1; 8 cycles total.
- beq with zero=1 → BRANCH pc_we=1, pc_src=1; beq zero=0 → pc_we=0; bne zero=0 → pc_we=1.
- sra (funct 0x03) → alu_op=8, src_a=2; lui (0x0F) → alu_op=9, src_b=3, reg_dst=0 in ALU_WB.
- opcode 0x3F → illegal=1 for exactly one DECODE cycle; no write enables; FETCH next.

Source files
------------

// File: rtl/mc_pkg.sv
`default_nettype none
// ============================================================================
// Module      : mc_pkg
// Description : Shared encodings for the multi-cycle MIPS control unit: ALU
//               operation codes, FSM states, instruction classes, datapath
//               mux selects and opcode/funct constants.
// Revision    : 1.0 - initial release
// ============================================================================
package mc_pkg;

    // ALU operation codes, shared with the ALU
    localparam logic [3:0] ALU_NOP = 4'd0;
    localparam logic [3:0] ALU_ADD = 4'd1;
    localparam logic [3:0] ALU_SUB = 4'd2;
    localparam logic [3:0] ALU_AND = 4'd3;
    localparam logic [3:0] ALU_OR  = 4'd4;
    localparam logic [3:0] ALU_XOR = 4'd5;
    localparam logic [3:0] ALU_SLL = 4'd6;
    localparam logic [3:0] ALU_SRL = 4'd7;
    localparam logic [3:0] ALU_SRA = 4'd8;
    localparam logic [3:0] ALU_LUI = 4'd9;

    // Controller states
    typedef enum logic [3:0] {
        S_FETCH     = 4'd0,
        S_DECODE    = 4'd1,
        S_MEM_ADDR  = 4'd2,
        S_MEM_READ  = 4'd3,
        S_MEM_WB    = 4'd4,
        S_MEM_WRITE = 4'd5,
        S_EXEC_R    = 4'd6,
        S_EXEC_I    = 4'd7,
        S_ALU_WB    = 4'd8,
        S_BRANCH    = 4'd9,
        S_JUMP      = 4'd10
    } state_t;

    // Instruction classes produced by the decoder
    typedef enum logic [2:0] {
        CLS_ILL = 3'd0,
        CLS_R   = 3'd1,
        CLS_I   = 3'd2,
        CLS_LW  = 3'd3,
        CLS_SW  = 3'd4,
        CLS_BEQ = 3'd5,
        CLS_BNE = 3'd6,
        CLS_J   = 3'd7
    } cls_t;

    // ALU operand A select
    localparam logic [1:0] SRC_A_PC    = 2'd0;
    localparam logic [1:0] SRC_A_RS    = 2'd1;
    localparam logic [1:0] SRC_A_SHAMT = 2'd2;

    // ALU operand B select
    localparam logic [2:0] SRC_B_RT       = 3'd0;
    localparam logic [2:0] SRC_B_FOUR     = 3'd1;
    localparam logic [2:0] SRC_B_SEXT     = 3'd2;
    localparam logic [2:0] SRC_B_ZEXT     = 3'd3;
    localparam logic [2:0] SRC_B_SEXT_SH2 = 3'd4;

    // PC source select
    localparam logic [1:0] PC_SRC_ALU    = 2'd0;
    localparam logic [1:0] PC_SRC_ALUOUT = 2'd1;
    localparam logic [1:0] PC_SRC_JUMP   = 2'd2;

    // Opcodes
    localparam logic [5:0] OP_RTYPE = 6'h00;
    localparam logic [5:0] OP_J     = 6'h02;
    localparam logic [5:0] OP_BEQ   = 6'h04;
    localparam logic [5:0] OP_BNE   = 6'h05;
    localparam logic [5:0] OP_ADDI  = 6'h08;
    localparam logic [5:0] OP_ADDIU = 6'h09;
    localparam logic [5:0] OP_ANDI  = 6'h0C;
    localparam logic [5:0] OP_ORI   = 6'h0D;
    localparam logic [5:0] OP_XORI  = 6'h0E;
    localparam logic [5:0] OP_LUI   = 6'h0F;
    localparam logic [5:0] OP_LW    = 6'h23;
    localparam logic [5:0] OP_SW    = 6'h2B;

    // R-type funct codes
    localparam logic [5:0] FN_SLL  = 6'h00;
    localparam logic [5:0] FN_SRL  = 6'h02;
    localparam logic [5:0] FN_SRA  = 6'h03;
    localparam logic [5:0] FN_ADD  = 6'h20;
    localparam logic [5:0] FN_ADDU = 6'h21;
    localparam logic [5:0] FN_SUB  = 6'h22;
    localparam logic [5:0] FN_SUBU = 6'h23;
    localparam logic [5:0] FN_AND  = 6'h24;
    localparam logic [5:0] FN_OR   = 6'h25;
    localparam logic [5:0] FN_XOR  = 6'h26;

    // Shift ops take operand A from the shamt field instead of rs
    function automatic logic is_shift(input logic [3:0] op);
        return (op == ALU_SLL) || (op == ALU_SRL) || (op == ALU_SRA);
    endfunction

endpackage
`default_nettype wire

// File: rtl/mc_ctrl_if.sv
`default_nettype none
// ============================================================================
// Module      : mc_ctrl_if
// Description : Control bundle between the multi-cycle controller (master)
//               and the MIPS datapath / memory (slave).
// Revision    : 1.0 - initial release
// ============================================================================
interface mc_ctrl_if;
    logic [5:0] opcode;
    logic [5:0] funct;
    logic       zero;
    logic       mem_rdy;
    logic       mem_req;
    logic       mem_we;
    logic       iord;
    logic       ir_we;
    logic       pc_we;
    logic [1:0] pc_src;
    logic       rf_we;
    logic       reg_dst;
    logic       mem_to_reg;
    logic [1:0] alu_src_a;
    logic [2:0] alu_src_b;
    logic [3:0] alu_op;
    logic       illegal;

    modport master (
        input  opcode, funct, zero, mem_rdy,
        output mem_req, mem_we, iord, ir_we, pc_we, pc_src, rf_we, reg_dst,
               mem_to_reg, alu_src_a, alu_src_b, alu_op, illegal
    );

    modport slave (
        output opcode, funct, zero, mem_rdy,
        input  mem_req, mem_we, iord, ir_we, pc_we, pc_src, rf_we, reg_dst,
               mem_to_reg, alu_src_a, alu_src_b, alu_op, illegal
    );
endinterface
`default_nettype wire

// File: rtl/mc_ctrl_dec.sv
`default_nettype none
// ============================================================================
// Module      : mc_ctrl_dec
// Description : Combinational instruction decoder. Maps opcode/funct to the
//               instruction class, the execute-stage ALU op and operand B
//               select, and a legal flag.
// Revision    : 1.0 - initial release
// ============================================================================
module mc_ctrl_dec
    import mc_pkg::*;
(
    input  wire logic [5:0] i_opcode,
    input  wire logic [5:0] i_funct,
    output cls_t            o_cls,
    output logic [3:0]      o_alu_op,
    output logic [2:0]      o_alu_src_b,
    output logic            o_legal
);

    // Opcode/funct lookup; anything unrecognised falls through as illegal
    always_comb begin
        o_cls       = CLS_ILL;
        o_alu_op    = ALU_NOP;
        o_alu_src_b = SRC_B_RT;
        o_legal     = 1'b1;
        case (i_opcode)
            OP_RTYPE: begin
                o_cls = CLS_R;
                case (i_funct)
                    FN_ADD, FN_ADDU: o_alu_op = ALU_ADD;
                    FN_SUB, FN_SUBU: o_alu_op = ALU_SUB;
                    FN_AND:          o_alu_op = ALU_AND;
                    FN_OR:           o_alu_op = ALU_OR;
                    FN_XOR:          o_alu_op = ALU_XOR;
                    FN_SLL:          o_alu_op = ALU_SLL;
                    FN_SRL:          o_alu_op = ALU_SRL;
                    FN_SRA:          o_alu_op = ALU_SRA;
                    default: begin
                        o_cls   = CLS_ILL;
                        o_legal = 1'b0;
                    end
                endcase
            end
            OP_ADDI, OP_ADDIU: begin
                o_cls       = CLS_I;
                o_alu_op    = ALU_ADD;
                o_alu_src_b = SRC_B_SEXT;
            end
            OP_ANDI: begin
                o_cls       = CLS_I;
                o_alu_op    = ALU_AND;
                o_alu_src_b = SRC_B_ZEXT;
            end
            OP_ORI: begin
                o_cls       = CLS_I;
                o_alu_op    = ALU_OR;
                o_alu_src_b = SRC_B_ZEXT;
            end
            OP_XORI: begin
                o_cls       = CLS_I;
                o_alu_op    = ALU_XOR;
                o_alu_src_b = SRC_B_ZEXT;
            end
            OP_LUI: begin
                o_cls       = CLS_I;
                o_alu_op    = ALU_LUI;
                o_alu_src_b = SRC_B_ZEXT;
            end
            OP_LW:  o_cls = CLS_LW;
            OP_SW:  o_cls = CLS_SW;
            OP_BEQ: o_cls = CLS_BEQ;
            OP_BNE: o_cls = CLS_BNE;
            OP_J:   o_cls = CLS_J;
            default: o_legal = 1'b0;
        endcase
    end

endmodule
`default_nettype wire

// File: rtl/mc_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : mc_ctrl
// Description : Multi-cycle MIPS control unit. Sequences each instruction
//               through fetch/decode/execute/memory/writeback and drives
//               the datapath selects, write enables and ALU op code.
// Revision    : 1.0 - initial release
// ============================================================================
module mc_ctrl
    import mc_pkg::*;
(
    input  wire logic   clk,
    input  wire logic   rst,
    mc_ctrl_if.master   ctl
);

    state_t     r_state;
    state_t     w_next;
    cls_t       w_cls;
    logic [3:0] w_dec_op;
    logic [2:0] w_dec_src_b;
    logic       w_legal;

    logic       w_mem_req;
    logic       w_mem_we;
    logic       w_iord;
    logic       w_ir_we;
    logic       w_pc_we;
    logic [1:0] w_pc_src;
    logic       w_rf_we;
    logic       w_reg_dst;
    logic       w_mem_to_reg;
    logic [1:0] w_alu_src_a;
    logic [2:0] w_alu_src_b;
    logic [3:0] w_alu_op;
    logic       w_illegal;

    mc_ctrl_dec u_dec (
        .i_opcode    (ctl.opcode),
        .i_funct     (ctl.funct),
        .o_cls       (w_cls),
        .o_alu_op    (w_dec_op),
        .o_alu_src_b (w_dec_src_b),
        .o_legal     (w_legal)
    );

    // State register; reset returns to FETCH immediately, even mid-stall
    always_ff @(posedge clk or posedge rst) begin
        if (rst) r_state <= S_FETCH;
        else     r_state <= w_next;
    end

    // Next-state selection; memory states hold until mem_rdy
    always_comb begin
        w_next = r_state;
        case (r_state)
            S_FETCH:     w_next = ctl.mem_rdy ? S_DECODE : S_FETCH;
            S_DECODE: begin
                case (w_cls)
                    CLS_R:           w_next = S_EXEC_R;
                    CLS_I:           w_next = S_EXEC_I;
                    CLS_LW, CLS_SW:  w_next = S_MEM_ADDR;
                    CLS_BEQ, CLS_BNE: w_next = S_BRANCH;
                    CLS_J:           w_next = S_JUMP;
                    default:         w_next = S_FETCH;
                endcase
            end
            S_MEM_ADDR:  w_next = (w_cls == CLS_SW) ? S_MEM_WRITE :
                                  (w_cls == CLS_LW) ? S_MEM_READ  : S_FETCH;
            S_MEM_READ:  w_next = ctl.mem_rdy ? S_MEM_WB : S_MEM_READ;
            S_MEM_WRITE: w_next = ctl.mem_rdy ? S_FETCH  : S_MEM_WRITE;
            S_MEM_WB:    w_next = S_FETCH;
            S_EXEC_R:    w_next = S_ALU_WB;
            S_EXEC_I:    w_next = S_ALU_WB;
            S_ALU_WB:    w_next = S_FETCH;
            S_BRANCH:    w_next = S_FETCH;
            S_JUMP:      w_next = S_FETCH;
            default:     w_next = S_FETCH;
        endcase
    end

    // Per-state datapath controls; everything not named for a state is 0
    always_comb begin
        w_mem_req    = 1'b0;
        w_mem_we     = 1'b0;
        w_iord       = 1'b0;
        w_ir_we      = 1'b0;
        w_pc_we      = 1'b0;
        w_pc_src     = PC_SRC_ALU;
        w_rf_we      = 1'b0;
        w_reg_dst    = 1'b0;
        w_mem_to_reg = 1'b0;
        w_alu_src_a  = SRC_A_PC;
        w_alu_src_b  = SRC_B_RT;
        w_alu_op     = ALU_NOP;
        w_illegal    = 1'b0;
        case (r_state)
            S_FETCH: begin
                w_mem_req   = 1'b1;
                w_alu_src_b = SRC_B_FOUR;
                w_alu_op    = ALU_ADD;
                w_ir_we     = ctl.mem_rdy;
                w_pc_we     = ctl.mem_rdy;
            end
            S_DECODE: begin
                // Speculatively compute the branch target into ALUOut
                w_alu_src_b = SRC_B_SEXT_SH2;
                w_alu_op    = ALU_ADD;
                w_illegal   = ~w_legal;
            end
            S_EXEC_R: begin
                w_alu_src_a = is_shift(w_dec_op) ? SRC_A_SHAMT : SRC_A_RS;
                w_alu_src_b = SRC_B_RT;
                w_alu_op    = w_dec_op;
            end
            S_EXEC_I: begin
                w_alu_src_a = SRC_A_RS;
                w_alu_src_b = w_dec_src_b;
                w_alu_op    = w_dec_op;
            end
            S_ALU_WB: begin
                w_rf_we   = 1'b1;
                w_reg_dst = (w_cls == CLS_R);
            end
            S_MEM_ADDR: begin
                w_alu_src_a = SRC_A_RS;
                w_alu_src_b = SRC_B_SEXT;
                w_alu_op    = ALU_ADD;
            end
            S_MEM_READ: begin
                w_mem_req = 1'b1;
                w_iord    = 1'b1;
            end
            S_MEM_WRITE: begin
                w_mem_req = 1'b1;
                w_mem_we  = 1'b1;
                w_iord    = 1'b1;
            end
            S_MEM_WB: begin
                w_rf_we      = 1'b1;
                w_mem_to_reg = 1'b1;
            end
            S_BRANCH: begin
                w_alu_src_a = SRC_A_RS;
                w_alu_src_b = SRC_B_RT;
                w_alu_op    = ALU_SUB;
                w_pc_src    = PC_SRC_ALUOUT;
                w_pc_we     = (w_cls == CLS_BNE) ? ~ctl.zero : ctl.zero;
            end
            S_JUMP: begin
                w_pc_src = PC_SRC_JUMP;
                w_pc_we  = 1'b1;
            end
            default: ;
        endcase
    end

    // Write enables are suppressed for the whole time reset is held
    assign ctl.mem_req    = w_mem_req;
    assign ctl.mem_we     = w_mem_we & ~rst;
    assign ctl.iord       = w_iord;
    assign ctl.ir_we      = w_ir_we & ~rst;
    assign ctl.pc_we      = w_pc_we & ~rst;
    assign ctl.pc_src     = w_pc_src;
    assign ctl.rf_we      = w_rf_we & ~rst;
    assign ctl.reg_dst    = w_reg_dst;
    assign ctl.mem_to_reg = w_mem_to_reg;
    assign ctl.alu_src_a  = w_alu_src_a;
    assign ctl.alu_src_b  = w_alu_src_b;
    assign ctl.alu_op     = w_alu_op;
    assign ctl.illegal    = w_illegal;

endmodule
`default_nettype wire
